mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal). It sequences a shared-ALU, shared-memory datapath through a Moore state machine. Per cycle it drives mux selects, register enables and the ALU operation. It sits beside the multicycle datapath and replaces the single-cycle decode path. An optional memory wait-state handshake stalls instruction and data accesses.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  7  instruction[6:0] from instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory access completes this cycle (used only with MC_MEMWAIT_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IllegalOp  out  1  unsupported opcode seen in Decode
- State  out  4  current state encoding, for debug/verification

## Operation
- States and encodings: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ExecuteI 7, ALUWB 8, BEQ 9, JAL 10. Encodings 11–15 go to Fetch.
- Transitions:
  - Fetch→Decode.
  - Decode→MemAdr (op 0000011 or 0100011), ExecuteR (0110011), ExecuteI (0010011), BEQ (1100011), JAL (1101111), otherwise Fetch.
  - MemAdr→MemRead (lw) or MemWrite (sw).
  - MemRead→MemWB→Fetch.
  - MemWrite→Fetch.
  - ExecuteR/ExecuteI→ALUWB→Fetch.
  - BEQ→Fetch.
  - JAL→ALUWB.
- Per-state outputs. Any field not listed is 0/00.
  - Fetch: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, PCUpdate 1.
  - Decode: ALUSrcA 01, ALUSrcB 01, add (branch/jump target into ALUOut).
  - MemAdr: ALUSrcA 10, ALUSrcB 01, add.
  - MemRead: ResultSrc 00, AdrSrc 1.
  - MemWB: ResultSrc 01, RegWrite 1.
  - MemWrite: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - ExecuteR: ALUSrcA 10, ALUSrcB 00, ALUOp funct.
  - ExecuteI: ALUSrcA 10, ALUSrcB 01, ALUOp funct.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00, Branch 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCUpdate 1.
- PCWrite = (Branch & Zero) | PCUpdate.
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, else 00.
- ALUControl with ALUOp funct, decoded by funct3:
  - 000: sub if (funct7b5 & op[5]), else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - other: add.
- IllegalOp = 1 only in Decode with an unsupported op. No datapath enables are asserted for that instruction.

## Timing
- Outputs are combinational from State (plus Zero and MemReady). State updates on the rising edge of clk.
- Reset:
  - State goes to Fetch on the first clk edge with reset=1.
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and IllegalOp are forced to 0. Mux selects take their Fetch values.
  - A reset mid-instruction abandons that instruction; no partial writes occur after the reset edge.
- Cycles per instruction (no wait states): lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- Fetch updates PC to PC+4 in the same edge that loads IR. beq reloads PC from ALUOut (target from Decode) only when Zero=1.

## Configuration
- MC_MEMWAIT_EN defined:
  - Fetch, MemRead and MemWrite hold their state while MemReady=0.
  - In Fetch, IRWrite and PCUpdate are gated by MemReady.
  - In MemWrite, MemWrite stays high until the MemReady cycle.
  - Exit from each of these states occurs on the edge where MemReady=1.
- MC_MEMWAIT_EN undefined: MemReady is ignored; each memory state lasts exactly one cycle.

## Test plan
- Reset held 3 cycles, then released → State=0, all enables 0 during reset; IRWrite=1 and PCWrite=1 in the first cycle after release.
- R-type add (op 0110011, funct3 000, funct7b5 0) → State sequence 0,1,6,8,0; ALUControl 000 in state 6; RegWrite=1 only in state 8. With funct7b5=1 → ALUControl 001.
- lw then sw → lw states 0,1,2,3,4 with ImmSrc 00 and RegWrite in state 4; sw states 0,1,2,5 with ImmSrc 01 and MemWrite=1 only in state 5.
- beq with Zero=1, then with Zero=0 → PCWrite=1 in state 9 for the first, 0 for the second; ALUControl 001 in both.
- jal → states 0,1,10,8; PCWrite=1 in state 10; ImmSrc 11. Op 1111111 → IllegalOp=1 in state 1, then back to state 0.
- MC_MEMWAIT_EN, MemReady=0 for 3 cycles in Fetch → State stays 0, IRWrite=PCWrite=0, then a single pulse when MemReady=1. Same for sw: MemWrite is high 4 cycles, then State=0.

Source files
------------

// File: rtl/mc_controller.sv
// Moore control unit for the multicycle RV32I subset datapath (lw, sw, R, I-ALU, beq, jal).
// Optional memory wait states are enabled by defining MC_MEMWAIT_EN.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   state_t     state, next;
   logic       mem_rdy;
   logic       is_lw, is_sw, is_r, is_i, is_beq, is_jal, legal;
   logic       pc_update, branch;
   logic [1:0] alu_op;

`ifdef MC_MEMWAIT_EN
   assign mem_rdy = MemReady;
`else
   // Memory always completes in one cycle; the handshake input is unused.
   logic unused_memready;
   assign unused_memready = MemReady;
   assign mem_rdy         = 1'b1;
`endif

   assign is_lw  = (op == OP_LW);
   assign is_sw  = (op == OP_SW);
   assign is_r   = (op == OP_R);
   assign is_i   = (op == OP_I);
   assign is_beq = (op == OP_BEQ);
   assign is_jal = (op == OP_JAL);
   assign legal  = is_lw | is_sw | is_r | is_i | is_beq | is_jal;

   always_comb begin
      next = S_FETCH;
      case (state)
         S_FETCH:    next = mem_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_lw || is_sw) next = S_MEMADR;
            else if (is_r)      next = S_EXECR;
            else if (is_i)      next = S_EXECI;
            else if (is_beq)    next = S_BEQ;
            else if (is_jal)    next = S_JAL;
            else                next = S_FETCH;
         end
         S_MEMADR:   next = is_sw ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next = mem_rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    next = S_FETCH;
         S_MEMWRITE: next = mem_rdy ? S_FETCH : S_MEMWRITE;
         S_EXECR:    next = S_ALUWB;
         S_EXECI:    next = S_ALUWB;
         S_ALUWB:    next = S_FETCH;
         S_BEQ:      next = S_FETCH;
         S_JAL:      next = S_ALUWB;
         default:    next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next;
   end

   assign State = state;

   // ImmSrc follows the opcode regardless of state so the extender is always ready.
   always_comb begin
      ImmSrc = 2'b00;
      if (is_sw)       ImmSrc = 2'b01;
      else if (is_beq) ImmSrc = 2'b10;
      else if (is_jal) ImmSrc = 2'b11;
   end

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      alu_op    = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            IRWrite   = mem_rdy;
            pc_update = mem_rdy;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b01;
            IllegalOp = ~legal;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
      // Reset kills every write strobe and parks the muxes on their Fetch settings.
      if (reset) begin
         pc_update = 1'b0;
         branch    = 1'b0;
         AdrSrc    = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         RegWrite  = 1'b0;
         IllegalOp = 1'b0;
         ResultSrc = 2'b10;
         ALUSrcA   = 2'b00;
         ALUSrcB   = 2'b10;
         alu_op    = ALUOP_ADD;
      end
   end

   assign PCWrite = (branch & Zero) | pc_update;

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         ALUOP_ADD: ALUControl = 3'b000;
         ALUOP_SUB: ALUControl = 3'b001;
         default: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle pushes the full expected
// control vector, which is popped and compared on the following falling edge.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset, Zero, MemReady, funct7b5;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   // Values staged for the next cycle; copied onto the DUT just after a rising edge.
   logic       n_rst = 1'b1, n_zero = 1'b0, n_mr = 1'b1, n_f7 = 1'b0;
   logic [6:0] n_op = 7'd0;
   logic [2:0] n_f3 = 3'd0;

   int ntests = 0;
   int nfail  = 0;
   logic [20:0] sb_q[$];

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .IllegalOp(IllegalOp), .State(State)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl, IllegalOp}
   function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb, input logic rw,
                                       input logic [1:0] imm, input logic [2:0] alu, input logic ill);
      return {st, pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill};
   endfunction

   function automatic logic [20:0] e_fetch(input logic [1:0] imm);
      return mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0);
   endfunction
   function automatic logic [20:0] e_dec(input logic [1:0] imm, input logic ill);
      return mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, ill);
   endfunction
   function automatic logic [20:0] e_wb(input logic [1:0] imm);
      return mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, imm, 3'b000, 1'b0);
   endfunction
   function automatic logic [20:0] e_rst(input logic [3:0] st, input logic [1:0] imm);
      return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0);
   endfunction

   task automatic cyc(input logic [20:0] e);
      @(posedge clk);
      #1;
      reset = n_rst; op = n_op; funct3 = n_f3; funct7b5 = n_f7; Zero = n_zero; MemReady = n_mr;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         logic [20:0] e;
         e = sb_q.pop_front();
         check($sformatf("st%0d", e[20:17]),
               {11'd0, State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, IllegalOp}, {11'd0, e});
      end
   end

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      n_rst = 1'b0; n_op = o; n_f3 = f3; n_f7 = f7;
   endtask

   task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [2:0] alu);
      set_instr(o, f3, f7);
      cyc(e_fetch(2'b00));
      cyc(e_dec(2'b00, 1'b0));
      if (o == OP_R) cyc(mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, alu, 1'b0));
      else           cyc(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, alu, 1'b0));
      cyc(e_wb(2'b00));
   endtask

   task automatic lw_instr();
      set_instr(OP_LW, 3'b010, 1'b0);
      cyc(e_fetch(2'b00));
      cyc(e_dec(2'b00, 1'b0));
      cyc(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0));
      cyc(mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0));
      cyc(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0));
   endtask

   task automatic sw_head();
      set_instr(OP_SW, 3'b010, 1'b0);
      cyc(e_fetch(2'b01));
      cyc(e_dec(2'b01, 1'b0));
      cyc(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000, 1'b0));
   endtask

   task automatic beq_instr(input logic z);
      set_instr(OP_BEQ, 3'b000, 1'b0);
      n_zero = z;
      cyc(e_fetch(2'b10));
      cyc(e_dec(2'b10, 1'b0));
      cyc(mk(4'd9, z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0));
      n_zero = 1'b0;
   endtask

   initial begin
      reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      // reset held three cycles
      repeat (3) cyc(e_rst(4'd0, 2'b00));

      alu_instr(OP_R, 3'b000, 1'b0, 3'b000);   // add
      alu_instr(OP_R, 3'b000, 1'b1, 3'b001);   // sub
      alu_instr(OP_R, 3'b010, 1'b0, 3'b101);   // slt
      alu_instr(OP_R, 3'b111, 1'b0, 3'b010);   // and
      alu_instr(OP_R, 3'b110, 1'b0, 3'b011);   // or
      alu_instr(OP_R, 3'b100, 1'b0, 3'b000);   // unsupported funct3 -> add
      alu_instr(OP_I, 3'b000, 1'b1, 3'b000);   // addi: funct7b5 ignored without op[5]
      alu_instr(OP_I, 3'b110, 1'b0, 3'b011);   // ori

      lw_instr();
      sw_head();
      cyc(mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));

      beq_instr(1'b1);
      beq_instr(1'b0);

      set_instr(OP_JAL, 3'b000, 1'b0);
      cyc(e_fetch(2'b11));
      cyc(e_dec(2'b11, 1'b0));
      cyc(mk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b11, 3'b000, 1'b0));
      cyc(e_wb(2'b11));

      set_instr(7'b1111111, 3'b000, 1'b0);
      cyc(e_fetch(2'b00));
      cyc(mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 1'b1));

      // reset asserted in MemRead abandons the load
      set_instr(OP_LW, 3'b010, 1'b0);
      cyc(e_fetch(2'b00));
      cyc(e_dec(2'b00, 1'b0));
      cyc(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0));
      n_rst = 1'b1;
      cyc(e_rst(4'd3, 2'b00));
      cyc(e_rst(4'd0, 2'b00));
      alu_instr(OP_R, 3'b000, 1'b0, 3'b000);

`ifdef MC_MEMWAIT_EN
      // Fetch stalls three cycles, then a single enable pulse
      set_instr(OP_R, 3'b000, 1'b0);
      n_mr = 1'b0;
      repeat (3) cyc(e_rst(4'd0, 2'b00));
      n_mr = 1'b1;
      cyc(e_fetch(2'b00));
      cyc(e_dec(2'b00, 1'b0));
      cyc(mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0));
      cyc(e_wb(2'b00));
      // sw with MemWrite held for four cycles
      sw_head();
      n_mr = 1'b0;
      repeat (3) cyc(mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
      n_mr = 1'b1;
      cyc(mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
      set_instr(OP_R, 3'b111, 1'b0);
      cyc(e_fetch(2'b00));
`else
      // MemReady low must not stall anything in the default build
      n_mr = 1'b0;
      alu_instr(OP_R, 3'b111, 1'b0, 3'b010);
      sw_head();
      cyc(mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
      n_mr = 1'b1;
      set_instr(OP_R, 3'b111, 1'b0);
      cyc(e_fetch(2'b00));
`endif

      @(posedge clk);
      @(negedge clk);
      #1;
      check("drain", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
